// File: rtl/game_state_ctrl.sv
// game_state_ctrl: tracks health, score and level from gameplay events and
// runs the game-phase FSM (IDLE / PLAY / LEVEL_UP / OVER).
// Every event input is edge-detected in the clk domain. A rising edge updates
// the counters at the clk edge that samples it.
// Optional build macro HEAL_ON_LEVEL_EN: health is reloaded to HEALTH_INIT on
// entry to LEVEL_UP, and any collision damage in that cycle is applied after
// the reload. When the macro is undefined, health carries across levels.
module game_state_ctrl #(
    parameter int HEALTH_W    = 13,
    parameter int SCORE_W     = 13,
    parameter int LVL_W       = 13,
    parameter int HEALTH_INIT = 100,
    parameter int HIT_CH      = 2,
    parameter int POINTS_W    = 5,
    parameter int LVL_MAX     = 99
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [HIT_CH-1:0]   collision,
    input  logic                capture,
    input  logic                landed,
    input  logic [POINTS_W-1:0] points,
    output logic [HEALTH_W-1:0] health,
    output logic [SCORE_W-1:0]  score,
    output logic [LVL_W-1:0]    lvl,
    output logic [1:0]          state,
    output logic                landing_en,
    output logic                next_lvl,
    output logic                fail
);

    localparam int                 CNT_W          = $clog2(HIT_CH + 1);
    localparam logic [HEALTH_W-1:0] LP_HEALTH_INIT = HEALTH_W'(HEALTH_INIT);
    localparam logic [LVL_W-1:0]    LP_LVL_MAX     = LVL_W'(LVL_MAX);
    localparam logic [LVL_W-1:0]    LP_LVL_ONE     = LVL_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PLAY     = 2'd1,
        ST_LEVEL_UP = 2'd2,
        ST_OVER     = 2'd3
    } state_t;

    // FSM and counter state
    state_t              r_state;
    logic [HEALTH_W-1:0] r_health;
    logic [SCORE_W-1:0]  r_score;
    logic [LVL_W-1:0]    r_lvl;
    logic                r_landing_en;
    logic                r_next_lvl;
    logic                r_fail;

    // Edge-detect history, one flop per input bit
    logic                r_start_q;
    logic [HIT_CH-1:0]   r_coll_q;
    logic                r_cap_q;
    logic                r_land_q;

    logic                w_start_edge;
    logic [HIT_CH-1:0]   w_coll_edge;
    logic                w_cap_edge;
    logic                w_land_edge;
    logic [CNT_W-1:0]    w_hit_cnt;
    logic [HEALTH_W-1:0] w_hit_ext;
    logic [HEALTH_W-1:0] w_health_dec;
    logic [HEALTH_W-1:0] w_health_lvlup;
    logic                w_health_zero;
    logic [SCORE_W-1:0]  w_score_inc;
    logic [LVL_W-1:0]    w_lvl_inc;
    logic                w_points_full;

    assign w_start_edge = start & ~r_start_q;
    assign w_coll_edge  = collision & ~r_coll_q;
    assign w_cap_edge   = capture & ~r_cap_q;
    assign w_land_edge  = landed & ~r_land_q;

    // Count how many collision channels rose in this cycle
    always_comb begin
        // NOTE: the default assignment comes first. Without it, a path that
        // skips the write would infer a latch.
        w_hit_cnt = '0;
        for (int i = 0; i < HIT_CH; i++) begin
            // NOTE: blocking assignments are correct here. Each loop pass must
            // see the running sum that the previous pass produced.
            w_hit_cnt = w_hit_cnt + CNT_W'(w_coll_edge[i]);
        end
    end

    assign w_hit_ext     = HEALTH_W'(w_hit_cnt);
    assign w_health_dec  = (r_health > w_hit_ext) ? (r_health - w_hit_ext) : '0;
    assign w_health_zero = (w_health_dec == '0);
    assign w_score_inc   = (w_cap_edge && (r_score != '1)) ? (r_score + SCORE_W'(1)) : r_score;
    assign w_lvl_inc     = (r_lvl >= LP_LVL_MAX) ? LP_LVL_MAX : (r_lvl + LP_LVL_ONE);
    assign w_points_full = &points;

`ifdef HEAL_ON_LEVEL_EN
    assign w_health_lvlup = (LP_HEALTH_INIT > w_hit_ext) ? (LP_HEALTH_INIT - w_hit_ext) : '0;
`else
    assign w_health_lvlup = w_health_dec;
`endif

    // Sample every event input into its history flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start_q <= 1'b0;
            r_coll_q  <= '0;
            r_cap_q   <= 1'b0;
            r_land_q  <= 1'b0;
        end else begin
            r_start_q <= start;
            r_coll_q  <= collision;
            r_cap_q   <= capture;
            r_land_q  <= landed;
        end
    end

    // Game-phase FSM with registered counters and flag outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_health     <= LP_HEALTH_INIT;
            r_score      <= '0;
            r_lvl        <= LP_LVL_ONE;
            r_landing_en <= 1'b0;
            r_next_lvl   <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            // The flags follow the state being entered. Each branch below
            // raises only the flags it needs.
            r_landing_en <= 1'b0;
            r_next_lvl   <= 1'b0;
            r_fail       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_edge) begin
                        r_health     <= LP_HEALTH_INIT;
                        r_score      <= '0;
                        r_lvl        <= LP_LVL_ONE;
                        r_state      <= ST_PLAY;
                        r_landing_en <= w_points_full;
                    end
                end
                ST_PLAY: begin
                    r_score <= w_score_inc;
                    if (w_health_zero) begin
                        // Death takes priority over a landing in the same cycle
                        r_health <= w_health_dec;
                        r_state  <= ST_OVER;
                        r_fail   <= 1'b1;
                    end else if (w_land_edge && r_landing_en) begin
                        r_health   <= w_health_lvlup;
                        r_lvl      <= w_lvl_inc;
                        r_state    <= ST_LEVEL_UP;
                        r_next_lvl <= 1'b1;
                    end else begin
                        r_health     <= w_health_dec;
                        r_landing_en <= w_points_full;
                    end
                end
                ST_LEVEL_UP: begin
                    r_health <= w_health_dec;
                    r_score  <= w_score_inc;
                    if (w_health_zero) begin
                        r_state <= ST_OVER;
                        r_fail  <= 1'b1;
                    end else begin
                        r_state      <= ST_PLAY;
                        r_landing_en <= w_points_full;
                    end
                end
                ST_OVER: begin
                    if (w_start_edge) begin
                        r_health     <= LP_HEALTH_INIT;
                        r_score      <= '0;
                        r_lvl        <= LP_LVL_ONE;
                        r_state      <= ST_PLAY;
                        r_landing_en <= w_points_full;
                    end else begin
                        r_fail <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign health     = r_health;
    assign score      = r_score;
    assign lvl        = r_lvl;
    assign state      = r_state;
    assign landing_en = r_landing_en;
    assign next_lvl   = r_next_lvl;
    assign fail       = r_fail;

endmodule
